// File: rtl/sipo_pkg.sv
// rtl/sipo_pkg.sv - shared types and constants for the SIPO deserializer
// Purpose: default word width, output FSM state type, bit-counter width helper.
package sipo_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } sipo_state_e;

    // Width of a counter that holds 0..w-1.
    function automatic int cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int DEFAULT_CNT_W = cnt_w(DEFAULT_WIDTH);

endpackage

// File: rtl/d_ff.sv
// rtl/d_ff.sv - single-bit D flip-flop with synchronous active-high reset
// Purpose: basic storage cell.
// Ports: clk (clock), rst (sync clear to 0), d (next value), q (stored value).
module d_ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/sipo_deserializer_shift.sv
// rtl/sipo_deserializer_shift.sv - MSB-first serial shift stage built from d_ff cells
// Purpose: WIDTH-bit left-shifting register; holds when en is low.
// Ports: clk, clr (sync clear, rst or align), en (shift qualifier), s_in (serial bit),
//        next_o (value loaded on the coming edge when not cleared; while en is high
//        this is {sh[WIDTH-2:0], s_in}, the candidate word).
module sipo_deserializer_shift #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             s_in,
    output logic [WIDTH-1:0] next_o
);

    logic [WIDTH-1:0] sh_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic shift_src;
        if (i == 0) begin : g_lsb
            assign shift_src = s_in;
        end else begin : g_upper
            assign shift_src = sh_q[i-1];
        end

        assign next_o[i] = en ? shift_src : sh_q[i];

        d_ff u_ff (
            .clk (clk),
            .rst (clr),
            .d   (next_o[i]),
            .q   (sh_q[i])
        );
    end

endmodule

// File: rtl/sipo_deserializer.sv
// rtl/sipo_deserializer.sv - serial-in parallel-out receiver with valid/ready output
// Purpose: collects MSB-first serial bits into WIDTH-bit words, presents each word on a
//          registered output with a valid/ready handshake, flags dropped words.
// Ports: clk, rst (sync active-high), align (drop partial word, clear overrun),
//        s_en/s_in (qualified serial bit), p_ready (consumer accept),
//        p_out/p_valid (output word), overrun (sticky drop flag), bit_cnt (partial count).
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int  WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             align,
    input  logic             s_en,
    input  logic             s_in,
    input  logic             p_ready,
    output logic [WIDTH-1:0] p_out,
    output logic             p_valid,
    output logic             overrun,
    output logic [CNT_W-1:0] bit_cnt
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] cand_word;
    logic             bit_take;
    logic             word_done;

    logic [CNT_W-1:0] bit_cnt_q;
    logic [CNT_W-1:0] bit_cnt_d;
    logic [WIDTH-1:0] p_out_q;
    logic             p_valid_q;
    logic             overrun_q;
    sipo_state_e      state_q;

    // align suppresses any bit on the same edge, so it also blocks completion.
    assign bit_take  = s_en & ~align;
    assign word_done = bit_take & (bit_cnt_q == LAST_BIT);

    sipo_deserializer_shift #(
        .WIDTH (WIDTH)
    ) u_shift (
        .clk    (clk),
        .clr    (rst | align),
        .en     (bit_take),
        .s_in   (s_in),
        .next_o (cand_word)
    );

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        if (align) begin
            bit_cnt_d = '0;
        end else if (bit_take) begin
            bit_cnt_d = word_done ? '0 : bit_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q <= '0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // Output FSM with registered p_out/p_valid/overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_EMPTY;
            p_out_q   <= '0;
            p_valid_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            // word_done is never set together with align, so this cannot race the set below.
            if (align) begin
                overrun_q <= 1'b0;
            end
            case (state_q)
                ST_EMPTY: begin
                    if (word_done) begin
                        p_out_q   <= cand_word;
                        p_valid_q <= 1'b1;
                        state_q   <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (word_done) begin
                        if (p_ready) begin
                            // Consumer takes the old word as the new one lands: no bubble.
                            p_out_q <= cand_word;
                        end else begin
                            overrun_q <= 1'b1;
                        end
                    end else if (p_ready) begin
                        p_valid_q <= 1'b0;
                        state_q   <= ST_EMPTY;
                    end
                end
                default: begin
                    state_q   <= ST_EMPTY;
                    p_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign p_out   = p_out_q;
    assign p_valid = p_valid_q;
    assign overrun = overrun_q;
    assign bit_cnt = bit_cnt_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// tb/tb_sipo_deserializer.sv - self-checking bench for sipo_deserializer
module tb_sipo_deserializer;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         align;
    logic         s_en;
    logic         s_in;
    logic         p_ready;
    logic [W-1:0] p_out;
    logic         p_valid;
    logic         overrun;
    logic [1:0]   bit_cnt;

    int checks = 0;
    int errors = 0;
    bit live   = 0;

    sipo_deserializer #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .align   (align),
        .s_en    (s_en),
        .s_in    (s_in),
        .p_ready (p_ready),
        .p_out   (p_out),
        .p_valid (p_valid),
        .overrun (overrun),
        .bit_cnt (bit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: the word is the last W accepted bits read as a number,
    // the output is a one-deep slot that is either empty or holds a word.
    int         m_part;
    int         m_cnt;
    logic [3:0] m_out;
    logic       m_valid;
    logic       m_ovr;
    int         t_part;
    int         t_cnt;
    logic [3:0] t_out;
    logic       t_valid;
    logic       t_ovr;
    logic       t_done;
    logic       t_xfer;

    always @(posedge clk) begin
        if (rst) begin
            m_part  <= 0;
            m_cnt   <= 0;
            m_out   <= '0;
            m_valid <= 1'b0;
            m_ovr   <= 1'b0;
        end else begin
            t_part  = m_part;
            t_cnt   = m_cnt;
            t_out   = m_out;
            t_valid = m_valid;
            t_ovr   = m_ovr;
            t_done  = 1'b0;
            t_xfer  = m_valid && p_ready;
            if (align) begin
                t_part = 0;
                t_cnt  = 0;
                t_ovr  = 1'b0;
            end else if (s_en) begin
                t_part = t_part * 2 + int'(s_in);
                t_cnt  = t_cnt + 1;
                if (t_cnt == W) t_done = 1'b1;
            end
            if (t_xfer) t_valid = 1'b0;
            if (t_done) begin
                if (!m_valid || t_xfer) begin
                    t_out   = t_part[3:0];
                    t_valid = 1'b1;
                end else begin
                    t_ovr = 1'b1;
                end
                t_part = 0;
                t_cnt  = 0;
            end
            m_part  <= t_part;
            m_cnt   <= t_cnt;
            m_out   <= t_out;
            m_valid <= t_valid;
            m_ovr   <= t_ovr;
        end
    end

    always @(negedge clk) begin
        if (live) begin
            chk("cyc_p_out",   32'(p_out),   32'(m_out));
            chk("cyc_p_valid", 32'(p_valid), 32'(m_valid));
            chk("cyc_overrun", 32'(overrun), 32'(m_ovr));
            chk("cyc_bit_cnt", 32'(bit_cnt), 32'(m_cnt));
        end
    end

    task automatic cyc(input logic r, input logic a, input logic e, input logic b, input logic rdy);
        rst     = r;
        align   = a;
        s_en    = e;
        s_in    = b;
        p_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic rdy);
        cyc(1'b0, 1'b0, 1'b1, b, rdy);
    endtask

    task automatic send_word(input logic [3:0] w, input logic rdy);
        for (int i = 3; i >= 0; i--) send_bit(w[i], rdy);
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, rdy);
    endtask

    initial begin
        logic [3:0] w;
        rst = 1'b1; align = 1'b0; s_en = 1'b0; s_in = 1'b0; p_ready = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        live = 1;
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("rst_p_out",   32'(p_out),   32'h0);
        chk("rst_p_valid", 32'(p_valid), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        chk("rst_bit_cnt", 32'(bit_cnt), 32'h0);

        // Basic word 1011, first bit lands in the MSB.
        send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b1); send_bit(1'b1, 1'b1);
        chk("t1_valid_early", 32'(p_valid), 32'h0);
        chk("t1_bit_cnt3",    32'(bit_cnt), 32'h3);
        send_bit(1'b1, 1'b1);
        chk("t1_p_out",   32'(p_out),   32'hB);
        chk("t1_p_valid", 32'(p_valid), 32'h1);
        chk("t1_overrun", 32'(overrun), 32'h0);
        chk("t1_bit_cnt", 32'(bit_cnt), 32'h0);
        idle(1'b1);
        chk("t1_valid_one_cycle", 32'(p_valid), 32'h0);
        chk("t1_p_out_hold",      32'(p_out),   32'hB);

        // Gapped s_en: bit_cnt holds across idle cycles.
        w = 4'b1100;
        for (int i = 3; i >= 0; i--) begin
            send_bit(w[i], 1'b1);
            if (i == 1) begin
                idle(1'b1);
                chk("t2_cnt_gap", 32'(bit_cnt), 32'h3);
            end else if (i != 0) begin
                idle(1'b1);
            end
        end
        chk("t2_word0", 32'(p_out), 32'hC);
        chk("t2_valid0", 32'(p_valid), 32'h1);
        idle(1'b1);
        w = 4'b0110;
        for (int i = 3; i >= 0; i--) begin
            send_bit(w[i], 1'b1);
            if (i != 0) idle(1'b1);
        end
        chk("t2_word1", 32'(p_out), 32'h6);
        idle(1'b1);

        // Overrun with p_ready low.
        send_word(4'b1010, 1'b0);
        chk("t3_word0", 32'(p_out), 32'hA);
        send_word(4'b0101, 1'b0);
        chk("t3_p_out_kept", 32'(p_out),   32'hA);
        chk("t3_valid",      32'(p_valid), 32'h1);
        chk("t3_overrun",    32'(overrun), 32'h1);
        idle(1'b1);
        chk("t3_drained",     32'(p_valid), 32'h0);
        chk("t3_ovr_sticky",  32'(overrun), 32'h1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t3_align_clr", 32'(overrun), 32'h0);

        // Back-to-back: ready arrives on the edge the next word completes.
        send_word(4'b1001, 1'b0);
        chk("t4_word0", 32'(p_out), 32'h9);
        send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
        chk("t4_hold_valid", 32'(p_valid), 32'h1);
        chk("t4_hold_out",   32'(p_out),   32'h9);
        send_bit(1'b1, 1'b1);
        chk("t4_word1",   32'(p_out),   32'h3);
        chk("t4_nobubble", 32'(p_valid), 32'h1);
        chk("t4_no_ovr",  32'(overrun), 32'h0);
        idle(1'b1);
        chk("t4_drained", 32'(p_valid), 32'h0);

        // Align discards stale bits and the bit sampled on the align edge.
        send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("t5_align_cnt", 32'(bit_cnt), 32'h0);
        send_word(4'b0001, 1'b1);
        chk("t5_word", 32'(p_out), 32'h1);
        idle(1'b1);

        // Align on the completing edge: no word.
        send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b1); send_bit(1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("t5b_no_word", 32'(p_valid), 32'h0);

        // Reset mid-word and with a word pending.
        send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b1); send_bit(1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("t6_rst_cnt", 32'(bit_cnt), 32'h0);
        chk("t6_rst_out", 32'(p_out),   32'h0);
        send_word(4'b1111, 1'b0);
        chk("t6_pending", 32'(p_valid), 32'h1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t6_rst_valid", 32'(p_valid), 32'h0);
        chk("t6_rst_out2",  32'(p_out),   32'h0);
        send_word(4'b1111, 1'b1);
        chk("t6_word", 32'(p_out), 32'hF);
        idle(1'b1);
        idle(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sipo_deserializer.md
# sipo_deserializer

Serial-in, parallel-out receiver: the receive-side counterpart of the team's PISO transmit register. Collects an MSB-first serial bit stream (one bit per enabled clock) into WIDTH-bit words and presents each complete word on a registered parallel output with a valid/ready handshake. It also provides overrun detection and a framing-align input. It sits at the far end of a serial link whose transmitter shifts left and drives its MSB as the serial bit.

## Interface
- WIDTH, 4, word length in bits; legal range ≥ 2
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden
- clk  input  1  rising-edge clock; the only clock
- rst  input  1  synchronous, active-high reset
- align  input  1  framing strobe; discards any partial word and restarts bit count at 0
- s_en  input  1  serial bit qualifier; s_in is sampled only when high
- s_in  input  1  serial data, MSB of each word first
- p_ready  input  1  consumer accepts p_out this cycle
- p_out  output  WIDTH  last completed word
- p_valid  output  1  p_out holds an unconsumed word
- overrun  output  1  sticky: a completed word was dropped
- bit_cnt  output  CNT_W  bits received in the current partial word

## Operation
- Shift register sh[WIDTH-1:0]: on clk edge with s_en=1 and align=0, sh <= {sh[WIDTH-2:0], s_in}; bit_cnt increments.
- Word completes on the edge where s_en=1, align=0 and bit_cnt==WIDTH-1. On that edge bit_cnt wraps to 0, and the candidate word is {sh[WIDTH-2:0], s_in}. The first received bit lands in p_out[WIDTH-1].
- Output FSM, 2 states:
  - EMPTY (p_valid=0): on word completion, load p_out and go to FULL.
  - FULL (p_valid=1):
    - p_ready=1 with no completion: go to EMPTY.
    - p_ready=1 with completion on the same edge: load the new word and stay in FULL. This is back-to-back transfer with no bubble.
    - p_ready=0 with completion: drop the new word, keep p_out, set overrun, stay in FULL.
- p_out changes only on a load; it holds its value in EMPTY.
- align=1: bit_cnt <= 0 and sh <= 0, and any s_en bit on that edge is discarded. align does not affect p_out or p_valid. align clears overrun.
- rst=1 overrides everything: sh=0, bit_cnt=0, p_out=0, p_valid=0, overrun=0, FSM=EMPTY.

## Timing
- Reset values: p_out=0, p_valid=0, overrun=0, bit_cnt=0.
- Latency: p_valid and the new p_out are visible the cycle after the edge that samples the last bit. With s_en held continuously, the first word is valid WIDTH cycles after the first bit.
- s_en may drop for any number of cycles mid-word; the partial word and bit_cnt hold.
- Handshake: transfer occurs on an edge with p_valid=1 and p_ready=1. p_ready while p_valid=0 has no effect. p_valid never drops without a transfer, except on rst.
- Sustained throughput is one word per WIDTH enabled bits, given p_ready=1. No overrun is possible if the consumer accepts within WIDTH cycles.
- Simultaneous events:
  - align with a completing bit: align wins; no word, no overrun.
  - rst mid-word or with p_valid=1: word lost, all state cleared on that edge.
- overrun stays set until align or rst.

## Structure
- Shared package sipo_pkg holds:
  - DEFAULT_WIDTH=4
  - the FSM state typedef (ST_EMPTY, ST_FULL)
  - a localparam helper for CNT_W
- Sub-module: the shift stage is built from the existing d_ff cell, one instance per bit, chained by generate. Each d_ff gets rst OR align as its reset and a mux-fed d, so shift hold when s_en=0.
- Counter, output register and FSM live in the top module.

## Test plan
- WIDTH=4, rst then s_en=1 with s_in 1,0,1,1 on consecutive cycles and p_ready=1 → p_out=4'b1011, p_valid=1 for exactly one cycle after the 4th bit, overrun=0.
- Stream 1,1,0,0 then 0,1,1,0 with s_en toggling 1/0 between bits and p_ready=1 → words 4'b1100 then 4'b0110, bit_cnt holds during gaps.
- p_ready=0, send 4'b1010 then 4'b0101 → p_out stays 4'b1010, p_valid=1, overrun=1 after the 8th bit. Then p_ready=1 → p_valid=0. Then align → overrun=0.
- Continuous s_en with p_ready asserted on the exact edge the next word completes → p_valid stays high, p_out goes 4'b1001 → 4'b0011 with no bubble.
- Send 2 bits 1,1, then align for one cycle (with s_en=1, s_in=1), then 0,0,0,1 → p_out=4'b0001. Stale and aligned bits are discarded.
- rst asserted after 3 bits and also while p_valid=1 → all outputs 0 the next cycle. The following 4 bits 1,1,1,1 → p_out=4'b1111.
